// File: rtl/oversample_tx_pkg.sv
// oversample_tx_pkg: frame geometry and FSM encoding shared by the oversampled UART transmitter and receiver.
package oversample_tx_pkg;
    localparam int SAMPLES_PER_BIT = 8;
    localparam int DATA_BITS = 8;
    localparam int FRAME_BITS = 10;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/oversample_tx_if.sv
// oversample_tx_if: byte handshake between a producer and the transmitter.
interface oversample_tx_if;
    logic [7:0] data;
    logic valid;
    logic ready;
    modport master (output data, valid, input ready);
    modport slave (input data, valid, output ready);
endinterface

// File: rtl/oversample_tx_sample_tick.sv
// sample_tick: divides clk by CLKS_PER_SAMPLE into a one-cycle tick; clr restarts the slot.
module sample_tick #(
    parameter int CLKS_PER_SAMPLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt;
    assign tick = cnt == 8'(CLKS_PER_SAMPLE - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (clr || tick) ? 8'd0 : cnt + 8'd1;
    end
endmodule

// File: rtl/oversample_tx.sv
// oversample_tx: 8N1 serial transmitter, each line bit held for 8 sample slots of CLKS_PER_SAMPLE clocks.
module oversample_tx
    import oversample_tx_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    oversample_tx_if.slave link,
    output logic tx,
    output logic busy
);
    state_t state, state_nx;
    logic [2:0] scnt, bidx;
    logic [7:0] sh;
    logic tick, bit_end, accept, clr, tx_nx;

    assign link.ready = state == IDLE;
    assign busy = state != IDLE;
    assign accept = link.valid && link.ready;
    assign bit_end = tick && scnt == 3'(SAMPLES_PER_BIT - 1);
    // counters restart on every state entry so each bit gets its full length
    assign clr = state == IDLE || state_nx != state;

    sample_tick #(.CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .tick(tick)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = accept ? START : IDLE;
            START: state_nx = bit_end ? DATA : START;
            DATA: state_nx = (bit_end && bidx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            STOP: state_nx = bit_end ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
        tx_nx = state_nx == START ? 1'b0 :
                state_nx == DATA ? ((state == DATA && bit_end) ? sh[1] : sh[0]) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tx <= 1'b1;
        end else begin
            state <= state_nx;
            tx <= tx_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            bidx <= '0;
            sh <= '0;
        end else begin
            scnt <= clr ? 3'd0 : tick ? scnt + 3'd1 : scnt;
            bidx <= state != DATA ? 3'd0 : bit_end ? bidx + 3'd1 : bidx;
            sh <= accept ? link.data : (state == DATA && bit_end) ? sh >> 1 : sh;
        end
    end
endmodule
